ecc_1_enc_pipe: RTL and testbench

//  Write-side companion of the ecc_<N>_top checkers. Computes the parity word for each

---
 rtl/ecc_1_enc_pipe_if.sv | 26 ++
 rtl/ecc_1_enc_pipe.sv | 147 ++++++++++++++
 tb/tb_ecc_1_enc_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_1_enc_pipe_if.sv
// Stream interface for the ECC write-side encoder pipe: an upstream
// valid/ready word channel and a downstream {data,parity} channel.
interface ecc_1_enc_pipe_if #(
  parameter int DATA_WIDTH   = 1,
  parameter int PARITY_WIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [PARITY_WIDTH-1:0] parity_out;

  // Producer/consumer side that drives the pipe.
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, parity_out
  );

  // The encoder pipe itself.
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, parity_out
  );
endinterface

// File: rtl/ecc_1_enc_pipe.sv
// ECC write-side encoder: computes the SECDED parity for each accepted word,
// stores {data,parity} in a 2-entry registered FIFO, and optionally corrupts
// one stored word via a one-shot injection FSM (IDLE/ARMED).
module ecc_1_enc_pipe #(
  parameter int DATA_WIDTH   = 1,
  parameter int PARITY_WIDTH = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_1_enc_pipe_if.slave      bus,
  input  logic                 bypass,
  input  logic                 inj_req,
  input  logic [1:0]           inj_mode,
  output logic                 inj_armed,
  output logic                 inj_done,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  typedef enum logic {ST_IDLE, ST_ARMED} state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_DOUBLE = 2'b10;

  // Hamming bits over positions 1..2^(P-1)-1 plus an overall parity bit in
  // the MSB. For one data bit every parity bit equals that data bit.
  function automatic logic [PARITY_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_WIDTH-1:0] p;
    logic [DATA_WIDTH-1:0]   sh;
    int                      k;
    p = '0;
    k = 0;
    for (int pos = 3; pos < (1 << (PARITY_WIDTH - 1)); pos++) begin
      if (((pos & (pos - 1)) != 0) && (k < DATA_WIDTH)) begin
        sh = d >> k;
        for (int j = 0; j < PARITY_WIDTH - 1; j++) begin
          if (((pos >> j) & 1) != 0) p[j] = p[j] ^ sh[0];
        end
        k++;
      end
    end
    p[PARITY_WIDTH-1] = (^d) ^ (^p[PARITY_WIDTH-2:0]);
    return p;
  endfunction

  logic [DATA_WIDTH-1:0]   r_data_mem [2];
  logic [PARITY_WIDTH-1:0] r_par_mem  [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  state_t                  r_state;
  logic [1:0]              r_mode;
  logic                    r_inj_done;
  logic [CNT_WIDTH-1:0]    r_word_cnt;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_inject;
  logic [DATA_WIDTH-1:0]   w_data_wr;
  logic [PARITY_WIDTH-1:0] w_par_wr;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready   = (r_count != 2'd2);
  assign bus.out_valid  = (r_count != 2'd0);
  assign bus.data_out   = r_data_mem[r_rd_ptr];
  assign bus.parity_out = r_par_mem[r_rd_ptr];
  assign inj_armed      = (r_state == ST_ARMED);
  assign inj_done       = r_inj_done;
  assign word_cnt       = r_word_cnt;

  assign w_push   = bus.in_valid & bus.in_ready;
  assign w_pop    = bus.out_valid & bus.out_ready;
  assign w_inject = (r_state == ST_ARMED) & w_push & ~bypass;

  // Encode the incoming word and apply the latched corruption if injecting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_data_wr = bus.data_in;
    w_par_wr  = ecc_encode(bus.data_in);
    if (w_inject) begin
      if (r_mode == MODE_SINGLE)      w_data_wr[0]  = ~w_data_wr[0];
      else if (r_mode == MODE_DOUBLE) w_par_wr[1:0] = ~w_par_wr[1:0];
    end
  end

  // 2-entry FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset because data_out/parity_out must read 0 after reset; it is only two entries.
      for (int i = 0; i < 2; i++) begin
        r_data_mem[i] <= '0;
        r_par_mem[i]  <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_push) begin
        r_data_mem[r_wr_ptr] <= w_data_wr;
        r_par_mem[r_wr_ptr]  <= w_par_wr;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Injection FSM with registered armed state and one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= 2'b00;
      r_inj_done <= 1'b0;
    end else begin
      r_inj_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (inj_req && !bypass && (inj_mode == MODE_SINGLE || inj_mode == MODE_DOUBLE)) begin
            r_state <= ST_ARMED;
            r_mode  <= inj_mode;
          end
        end
        ST_ARMED: begin
          if (bypass) begin
            r_state <= ST_IDLE;
          end else if (w_push) begin
            r_state    <= ST_IDLE;
            r_inj_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of accepted words.
  always_ff @(posedge clk) begin
    if (rst)                           r_word_cnt <= '0;
    else if (w_push && r_word_cnt != '1) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_ecc_1_enc_pipe.sv
// Self-checking bench for ecc_1_enc_pipe: a vector table of single-word
// encode/inject cases plus hand-written multi-cycle sequences.
module tb_ecc_1_enc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        bypass;
  logic        inj_req;
  logic [1:0]  inj_mode;
  logic        inj_armed, inj_done;
  logic [15:0] word_cnt;
  logic        sat_armed, sat_done;
  logic [1:0]  sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  ecc_1_enc_pipe_if #(.DATA_WIDTH(1), .PARITY_WIDTH(3)) bus ();
  ecc_1_enc_pipe_if #(.DATA_WIDTH(1), .PARITY_WIDTH(3)) sat_bus ();

  assign sat_bus.in_valid  = bus.in_valid;
  assign sat_bus.data_in   = bus.data_in;
  assign sat_bus.out_ready = bus.out_ready;

  ecc_1_enc_pipe #(.DATA_WIDTH(1), .PARITY_WIDTH(3), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .bypass(bypass), .inj_req(inj_req),
    .inj_mode(inj_mode), .inj_armed(inj_armed), .inj_done(inj_done), .word_cnt(word_cnt)
  );

  ecc_1_enc_pipe #(.DATA_WIDTH(1), .PARITY_WIDTH(3), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst(rst), .bus(sat_bus), .bypass(bypass), .inj_req(inj_req),
    .inj_mode(inj_mode), .inj_armed(sat_armed), .inj_done(sat_done), .word_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inj;
    logic [1:0] mode;
    logic       din;
    logic       exp_arm;
    logic       exp_d;
    logic [2:0] exp_p;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // One-cycle inj_req pulse with no data.
  task automatic arm(input logic [1:0] mode);
    inj_req  = 1'b1;
    inj_mode = mode;
    tick();
    inj_req  = 1'b0;
    inj_mode = 2'b00;
  endtask

  // Push one word with out_ready=1 and check the head on the next cycle.
  task automatic push_check(input string name, input logic din, input logic exp_d,
                            input logic [2:0] exp_p, input logic exp_done);
    bus.in_valid  = 1'b1;
    bus.data_in   = din;
    bus.out_ready = 1'b1;
    check({name, " in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    exp_cnt++;
    check({name, " out_valid"}, bus.out_valid, 1);
    check({name, " data"}, bus.data_out, exp_d);
    check({name, " parity"}, bus.parity_out, exp_p);
    check({name, " done"}, inj_done, exp_done);
    check({name, " cnt"}, word_cnt, exp_cnt);
    tick();
    check({name, " drained"}, bus.out_valid, 0);
    check({name, " done_clr"}, inj_done, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b111};
    vecs[1] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[2] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 3'b111};
    vecs[3] = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'b100};
    vecs[4] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[5] = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b011};
    vecs[6] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 3'b111};
    vecs[7] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 3'b000};

    rst = 1'b1; bypass = 1'b0; inj_req = 1'b0; inj_mode = 2'b00;
    bus.in_valid = 1'b0; bus.data_in = 1'b0; bus.out_ready = 1'b0;
    tick();
    do_reset();

    // Reset state.
    check("rst out_valid", bus.out_valid, 0);
    check("rst in_ready", bus.in_ready, 1);
    check("rst armed", inj_armed, 0);
    check("rst done", inj_done, 0);
    check("rst cnt", word_cnt, 0);
    check("rst data", bus.data_out, 0);
    check("rst parity", bus.parity_out, 0);

    // Table: encode and single-word injection cases.
    for (int i = 0; i < 8; i++) begin
      arm(vecs[i].inj ? vecs[i].mode : 2'b00);
      if (!vecs[i].inj) begin
        inj_req = 1'b0;
      end
      check($sformatf("v%0d armed", i), inj_armed, vecs[i].exp_arm);
      push_check($sformatf("v%0d", i), vecs[i].din, vecs[i].exp_d, vecs[i].exp_p, vecs[i].exp_arm);
      check($sformatf("v%0d disarmed", i), inj_armed, 0);
    end

    // Backpressure: push 1,0,1 with out_ready=0, then release.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = 1'b1;
    tick();
    bus.data_in = 1'b0;
    tick();
    bus.data_in = 1'b1;
    check("bp full in_ready", bus.in_ready, 0);
    check("bp head", bus.data_out, 1);
    tick();
    check("bp held in_ready", bus.in_ready, 0);
    check("bp held head", bus.data_out, 1);
    check("bp held parity", bus.parity_out, 3'b111);
    bus.out_ready = 1'b1;
    check("bp pop cycle in_ready", bus.in_ready, 0);
    tick();
    check("bp second head", bus.data_out, 0);
    check("bp second parity", bus.parity_out, 3'b000);
    check("bp reopen in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    exp_cnt += 3;
    check("bp third valid", bus.out_valid, 1);
    check("bp third head", bus.data_out, 1);
    check("bp cnt", word_cnt, exp_cnt);
    tick();
    check("bp empty", bus.out_valid, 0);

    // inj_req while ARMED is ignored; mode 01 stays latched.
    arm(2'b01);
    arm(2'b10);
    check("rearm armed", inj_armed, 1);
    push_check("rearm", 1'b1, 1'b0, 3'b111, 1'b1);

    // inj_req on the same edge as an IDLE accept does not touch that word.
    inj_req = 1'b1; inj_mode = 2'b01;
    bus.in_valid = 1'b1; bus.data_in = 1'b1; bus.out_ready = 1'b1;
    tick();
    inj_req = 1'b0; inj_mode = 2'b00; bus.in_valid = 1'b0;
    exp_cnt++;
    check("same_edge data", bus.data_out, 1);
    check("same_edge parity", bus.parity_out, 3'b111);
    check("same_edge done", inj_done, 0);
    check("same_edge armed", inj_armed, 1);
    tick();
    push_check("same_edge next", 1'b0, 1'b1, 3'b000, 1'b1);

    // bypass while ARMED disarms without a done pulse; bypass blocks arming.
    arm(2'b01);
    check("byp armed", inj_armed, 1);
    bypass = 1'b1;
    tick();
    check("byp disarm", inj_armed, 0);
    check("byp no done", inj_done, 0);
    arm(2'b10);
    check("byp blocks arm", inj_armed, 0);
    bypass = 1'b0;
    push_check("byp word", 1'b1, 1'b1, 3'b111, 1'b0);

    // Reset with buffered words and an armed injection.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    arm(2'b01);
    check("mid armed", inj_armed, 1);
    check("mid full", bus.in_ready, 0);
    do_reset();
    check("mid rst out_valid", bus.out_valid, 0);
    check("mid rst in_ready", bus.in_ready, 1);
    check("mid rst armed", inj_armed, 0);
    check("mid rst done", inj_done, 0);
    check("mid rst cnt", word_cnt, 0);
    check("mid rst data", bus.data_out, 0);
    check("mid rst parity", bus.parity_out, 0);
    push_check("post rst", 1'b1, 1'b1, 3'b111, 1'b0);
    check("post rst cnt", word_cnt, 1);

    // Saturating counter: CNT_WIDTH=2 instance reads 1,2,3,3,3.
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.data_in = k[0];
      tick();
      exp_cnt++;
      check($sformatf("sat cnt %0d", k), sat_cnt, (k > 3) ? 3 : k);
      check($sformatf("wide cnt %0d", k), word_cnt, exp_cnt);
      check($sformatf("stream head %0d", k), bus.data_out, k[0]);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sat final", sat_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
